// File: rtl/loader_pkg.sv
// Shared types and constants for the CHIP-8 game loader: FSM states, RAM map and font table.
package loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFont,
    StCopy,
    StDrain,
    StDone
  } state_e;

  localparam logic [11:0] FONT_BASE  = 12'h050;
  localparam logic [11:0] PROG_BASE  = 12'h200;
  localparam logic [11:0] CLEAR_TOP  = 12'h1FF;
  localparam int unsigned FONT_BYTES = 80;

  // Glyphs 0-F, five rows each; byte 0 sits in the most significant position.
  localparam logic [639:0] FONT_ROM = {
    40'hF0_90_90_90_F0, 40'h20_60_20_20_70, 40'hF0_10_F0_80_F0, 40'hF0_10_F0_10_F0,
    40'h90_90_F0_10_10, 40'hF0_80_F0_10_F0, 40'hF0_80_F0_90_F0, 40'hF0_10_20_40_40,
    40'hF0_90_F0_90_F0, 40'hF0_90_F0_10_F0, 40'hF0_90_F0_90_90, 40'hE0_90_E0_90_E0,
    40'hF0_80_80_80_F0, 40'hE0_90_90_90_E0, 40'hF0_80_F0_80_F0, 40'hF0_80_F0_80_80
  };

  function automatic logic [7:0] font_byte(input logic [6:0] idx);
    return FONT_ROM[639 - 8 * int'(idx) -: 8];
  endfunction

endpackage

// File: rtl/delay_line.sv
// Valid/data delay pipe matching the game ROM read latency; o_pending flags entries
// still in flight behind the output stage.
module delay_line #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_pending
);

  logic [DEPTH-1:0] r_valid;
  logic [WIDTH-1:0] r_data [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= '0;
    end else begin
      r_valid[0] <= i_valid;
      for (int i = 1; i < int'(DEPTH); i++) r_valid[i] <= r_valid[i-1];
    end
  end

  always_ff @(posedge i_clk) begin
    r_data[0] <= i_data;
    for (int i = 1; i < int'(DEPTH); i++) r_data[i] <= r_data[i-1];
  end

  always_comb begin
    o_pending = 1'b0;
    for (int i = 0; i < int'(DEPTH) - 1; i++) o_pending = o_pending | r_valid[i];
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/game_loader.sv
// Copies a game from ROM into CHIP-8 RAM after loading the font; the low-RAM clear pass
// is built only when LOADER_CLEAR_EN is defined.
module game_loader
  import loader_pkg::*;
#(
  parameter int unsigned ROM_LATENCY = 2,
  parameter int unsigned PROG_BYTES  = 3584
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic [3:0]  game_in,
  output logic        busy_out,
  output logic        done_out,
  output logic [15:0] rom_addr_out,
  input  logic [7:0]  rom_data_in,
  output logic [11:0] ram_addr_out,
  output logic [7:0]  ram_data_out,
  output logic        ram_we_out
);

  state_e      r_state;
  state_e      w_state_next;
  logic [3:0]  r_game;
  logic [11:0] r_cnt;
  logic        w_last;
  logic        w_pipe_valid;
  logic [11:0] w_pipe_addr;
  logic        w_pipe_pending;

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_comb begin
    unique case (r_state)
      StClear: w_last = (r_cnt == CLEAR_TOP);
      StFont:  w_last = (r_cnt == 12'(FONT_BYTES - 1));
      StCopy:  w_last = (r_cnt == 12'(PROG_BYTES - 1));
      default: w_last = 1'b0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (start_in) begin
`ifdef LOADER_CLEAR_EN
          w_state_next = StClear;
`else
          w_state_next = StFont;
`endif
        end
      end
`ifdef LOADER_CLEAR_EN
      StClear: if (w_last) w_state_next = StFont;
`endif
      StFont:  if (w_last) w_state_next = StCopy;
      StCopy:  if (w_last) w_state_next = StDrain;
      // The byte on the pipe output is written this cycle, so only later stages matter.
      StDrain: if (!w_pipe_pending) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_game <= '0;
      r_cnt  <= '0;
    end else begin
      if (r_state == StIdle && start_in) r_game <= game_in;
      if (w_state_next != r_state)                               r_cnt <= '0;
      else if (r_state inside {StClear, StFont, StCopy})         r_cnt <= r_cnt + 12'd1;
    end
  end

  delay_line #(
    .WIDTH (12),
    .DEPTH (ROM_LATENCY)
  ) u_pipe (
    .i_clk     (clk_in),
    .i_rst     (rst_in),
    .i_valid   (r_state == StCopy),
    .i_data    (PROG_BASE + r_cnt),
    .o_valid   (w_pipe_valid),
    .o_data    (w_pipe_addr),
    .o_pending (w_pipe_pending)
  );

  always_comb begin
    busy_out     = r_state inside {StClear, StFont, StCopy, StDrain};
    done_out     = (r_state == StDone);
    rom_addr_out = (r_state == StCopy) ? {r_game, r_cnt} : 16'h0000;
    ram_we_out   = 1'b0;
    ram_addr_out = 12'h000;
    ram_data_out = 8'h00;
    if (w_pipe_valid) begin
      ram_we_out   = 1'b1;
      ram_addr_out = w_pipe_addr;
      ram_data_out = rom_data_in;
    end else if (r_state == StFont) begin
      ram_we_out   = 1'b1;
      ram_addr_out = FONT_BASE + r_cnt;
      ram_data_out = font_byte(r_cnt[6:0]);
`ifdef LOADER_CLEAR_EN
    end else if (r_state == StClear) begin
      ram_we_out   = 1'b1;
      ram_addr_out = r_cnt;
`endif
    end
  end

endmodule

// File: tb/tb_game_loader.sv
// Scoreboard bench for game_loader: two instances (ROM latency 2 and 4) share stimulus;
// expected RAM writes and done times are queued at start and popped by per-DUT monitors.
module tb_game_loader;

  localparam int P     = 3584;
  localparam int LAT_A = 2;
  localparam int LAT_B = 4;
`ifdef LOADER_CLEAR_EN
  localparam int CLR = 512;
`else
  localparam int CLR = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [3:0] game = 4'h0;

  logic busy_a, done_a, we_a, busy_b, done_b, we_b;
  logic [15:0] rom_a, rom_b;
  logic [7:0]  rom_da, rom_db, ram_data_a, ram_data_b;
  logic [11:0] ram_addr_a, ram_addr_b;

  game_loader #(.ROM_LATENCY(LAT_A), .PROG_BYTES(P)) u_dut_a (
    .clk_in(clk), .rst_in(rst), .start_in(start), .game_in(game),
    .busy_out(busy_a), .done_out(done_a), .rom_addr_out(rom_a), .rom_data_in(rom_da),
    .ram_addr_out(ram_addr_a), .ram_data_out(ram_data_a), .ram_we_out(we_a)
  );

  game_loader #(.ROM_LATENCY(LAT_B), .PROG_BYTES(P)) u_dut_b (
    .clk_in(clk), .rst_in(rst), .start_in(start), .game_in(game),
    .busy_out(busy_b), .done_out(done_b), .rom_addr_out(rom_b), .rom_data_in(rom_db),
    .ram_addr_out(ram_addr_b), .ram_data_out(ram_data_b), .ram_we_out(we_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ROM: byte = offset[7:0], presented exactly LAT cycles after the address.
  logic [15:0] ha [4];
  logic [15:0] hb [4];
  initial for (int i = 0; i < 4; i++) begin ha[i] = 16'h0; hb[i] = 16'h0; end
  always @(posedge clk) begin
    ha[0] <= rom_a;
    hb[0] <= rom_b;
    for (int i = 1; i < 4; i++) begin ha[i] <= ha[i-1]; hb[i] <= hb[i-1]; end
  end
  assign rom_da = ha[LAT_A-1][7:0];
  assign rom_db = hb[LAT_B-1][7:0];

  int font_t [80] = '{
    'hF0,'h90,'h90,'h90,'hF0, 'h20,'h60,'h20,'h20,'h70, 'hF0,'h10,'hF0,'h80,'hF0,
    'hF0,'h10,'hF0,'h10,'hF0, 'h90,'h90,'hF0,'h10,'h10, 'hF0,'h80,'hF0,'h10,'hF0,
    'hF0,'h80,'hF0,'h90,'hF0, 'hF0,'h10,'h20,'h40,'h40, 'hF0,'h90,'hF0,'h90,'hF0,
    'hF0,'h90,'hF0,'h10,'hF0, 'hF0,'h90,'hF0,'h90,'h90, 'hE0,'h90,'hE0,'h90,'hE0,
    'hF0,'h80,'h80,'h80,'hF0, 'hE0,'h90,'h90,'h90,'hE0, 'hF0,'h80,'hF0,'h80,'hF0,
    'hF0,'h80,'hF0,'h80,'h80
  };

  logic [7:0]  ram_a [4096];
  logic [7:0]  ram_b [4096];
  logic [7:0]  exp_mem [4096];
  logic [19:0] qa [$];
  logic [19:0] qb [$];
  int          dqa [$];
  int          dqb [$];
  logic [3:0]  cur_game = 4'h0;
  int          start_cyc = 0;
  logic [19:0] ea, eb;

  always @(negedge clk) begin
    if (we_a) begin
      if (qa.size() == 0) chk("wr_a_unexpected", int'({ram_addr_a, ram_data_a}), 0);
      else begin
        ea = qa.pop_front();
        chk("wr_a", int'({ram_addr_a, ram_data_a}), int'(ea));
      end
      ram_a[ram_addr_a] = ram_data_a;
    end
    if (done_a) begin
      if (dqa.size() == 0) chk("done_a_unexpected", 1, 0);
      else chk("done_a_cycle", cyc, dqa.pop_front());
    end
    if (busy_a && rom_a != 16'h0) chk("rom_game_a", int'(rom_a[15:12]), int'(cur_game));
  end

  always @(negedge clk) begin
    if (we_b) begin
      if (qb.size() == 0) chk("wr_b_unexpected", int'({ram_addr_b, ram_data_b}), 0);
      else begin
        eb = qb.pop_front();
        chk("wr_b", int'({ram_addr_b, ram_data_b}), int'(eb));
      end
      ram_b[ram_addr_b] = ram_data_b;
    end
    if (done_b) begin
      if (dqb.size() == 0) chk("done_b_unexpected", 1, 0);
      else chk("done_b_cycle", cyc, dqb.pop_front());
    end
    if (busy_b && rom_b != 16'h0) chk("rom_game_b", int'(rom_b[15:12]), int'(cur_game));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input int a, input int d);
    logic [19:0] ent;
    ent = {12'(a), 8'(d)};
    qa.push_back(ent);
    qb.push_back(ent);
    exp_mem[a % 4096] = 8'(d);
  endtask

  // Caller sits just after a clock edge with both DUTs idle.
  task automatic start_load(input logic [3:0] g);
    start     = 1'b1;
    game      = g;
    cur_game  = g;
    start_cyc = cyc;
    for (int i = 0; i < CLR; i++) push_wr(i, 0);
    for (int i = 0; i < 80; i++) push_wr('h50 + i, font_t[i]);
    for (int k = 0; k < P; k++) push_wr(('h200 + k) % 4096, k % 256);
    dqa.push_back(cyc + CLR + 80 + P + LAT_A + 1);
    dqb.push_back(cyc + CLR + 80 + P + LAT_B + 1);
    tick();
    start = 1'b0;
    game  = 4'($urandom);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((dqa.size() != 0 || dqb.size() != 0) && n < 6000) begin
      tick();
      n++;
    end
    chk({name, "_finished"}, int'(n < 6000), 1);
    chk({name, "_writes_left_a"}, qa.size(), 0);
    chk({name, "_writes_left_b"}, qb.size(), 0);
    tick();
    chk({name, "_busy_after_a"}, int'(busy_a), 0);
  endtask

  task automatic check_image(input string name);
    int na = 0;
    int nb = 0;
    for (int i = 0; i < 4096; i++) begin
      if (ram_a[i] !== exp_mem[i]) na++;
      if (ram_b[i] !== exp_mem[i]) nb++;
    end
    chk({name, "_ram_a_diffs"}, na, 0);
    chk({name, "_ram_b_diffs"}, nb, 0);
  endtask

  initial begin
    int w;
    for (int i = 0; i < 4096; i++) begin
      exp_mem[i] = 8'($urandom);
      if (i == 0 || i == 'h1FF) exp_mem[i] = 8'hAA;
      ram_a[i] = exp_mem[i];
      ram_b[i] = exp_mem[i];
    end

    repeat (3) tick();
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_done_a", int'(done_a), 0);
    chk("rst_we_a", int'(we_a), 0);
    chk("rst_rom_addr_a", int'(rom_a), 0);
    chk("rst_ram_addr_a", int'(ram_addr_a), 0);
    chk("rst_ram_data_a", int'(ram_data_a), 0);
    chk("rst_busy_b", int'(busy_b), 0);
    chk("rst_we_b", int'(we_b), 0);
    rst = 1'b0;
    repeat (2) tick();

    // Load 1: game 3, with an ignored second request in the middle of COPY.
    start_load(4'd3);
    w = CLR + 80 + 20 + int'($urandom_range(0, 500));
    repeat (w) tick();
    start = 1'b1;
    game  = 4'($urandom);
    tick();
    start = 1'b0;
    wait_done("load1");
    chk("ram_200", int'(ram_a['h200]), 'h00);
    chk("ram_2ff", int'(ram_a['h2FF]), 'hFF);
    chk("ram_fff", int'(ram_a['hFFF]), 'hFF);
    chk("ram_050", int'(ram_a['h050]), 'hF0);
`ifdef LOADER_CLEAR_EN
    chk("ram_000_cleared", int'(ram_a['h000]), 0);
    chk("ram_1ff_cleared", int'(ram_a['h1FF]), 0);
`else
    chk("ram_000_kept", int'(ram_a['h000]), 'hAA);
    chk("ram_1ff_kept", int'(ram_a['h1FF]), 'hAA);
`endif
    check_image("load1");

    // Load 2: reset lands while COPY issues offset 100.
    repeat (int'($urandom_range(1, 5))) tick();
    start_load(4'($urandom));
    while (cyc < start_cyc + 1 + CLR + 80 + 100) tick();
    chk("abort_offset", int'(rom_a[11:0]), 100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    qa.delete();
    qb.delete();
    dqa.delete();
    dqb.delete();
    chk("abort_busy_a", int'(busy_a), 0);
    chk("abort_busy_b", int'(busy_b), 0);
    chk("abort_we_a", int'(we_a), 0);
    chk("abort_we_b", int'(we_b), 0);
    repeat (30) tick();

    // Loads 3-5: random slots and gaps, each a complete load.
    for (int n = 0; n < 3; n++) begin
      repeat (int'($urandom_range(1, 8))) tick();
      start_load(4'($urandom));
      wait_done("loadr");
      check_image("loadr");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
